fir_timing_ctrl: RTL and testbench

//  Parametrised timing/strobe generator for the DSP58 FIR datapath; successor to the fixed-length delay strobe logic.

---
 rtl/fir_timing_ctrl_pkg.sv | 24 ++
 rtl/fir_timing_ctrl_strobe_pipe.sv | 41 ++++
 rtl/fir_timing_ctrl.sv | 146 ++++++++++++++
 tb/tb_fir_timing_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_timing_ctrl_pkg.sv
// Package: fir_timing_ctrl_pkg
// Purpose: Shared types and helpers for the FIR timing/strobe controller.
//   state_t   : controller state encoding (IDLE=0, WARMUP=1, RUN=2, DRAIN=3)
//   clamp_len : limits a requested frame length to the range 2..max_len
package fir_timing_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // A frame needs at least two taps so that frame_start and frame_last
  // never coincide.
  function automatic int clamp_len(input int cfg, input int max_len);
    int res;
    res = cfg;
    if (cfg < 2) res = 2;
    else if (cfg > max_len) res = max_len;
    return res;
  endfunction

endpackage

// File: rtl/fir_timing_ctrl_strobe_pipe.sv
// Module: fir_timing_ctrl_strobe_pipe
// Purpose: DEPTH-stage {valid, ch} shift register that delays the frame_last
//   strobe by the DSP cascade latency. The channel field is zeroed whenever
//   valid is low so the output channel reads 0 outside a valid pulse.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears all stages)
//   in_valid/in_ch  strobe and channel entering the delay line
//   out_valid/out_ch strobe and channel DEPTH cycles later
module fir_timing_ctrl_strobe_pipe #(
  parameter int DEPTH = 4,
  parameter int CH_W  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [CH_W-1:0] in_ch,
  output logic            out_valid,
  output logic [CH_W-1:0] out_ch
);

  logic [DEPTH-1:0] valid_sr;
  logic [CH_W-1:0]  ch_sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
      for (int i = 0; i < DEPTH; i++) ch_sr[i] <= '0;
    end else begin
      valid_sr[0] <= in_valid;
      ch_sr[0]    <= in_valid ? in_ch : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        ch_sr[i]    <= ch_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[DEPTH-1];
  assign out_ch    = ch_sr[DEPTH-1];

endmodule

// File: rtl/fir_timing_ctrl.sv
// Module: fir_timing_ctrl
// Purpose: Tap/channel sequencer and strobe generator for a TDM multi-channel
//   FIR on a DSP58 cascade. Handles start/stop, a fixed warm-up period,
//   runtime frame length (clamped to 2..MAX_LEN) and a result-valid strobe
//   aligned to the DSP pipeline latency.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin request (only honoured in IDLE)
//   stop         finish current frame, then drain
//   en           tap advance enable
//   len_cfg      taps per frame, sampled at start and at each frame boundary
//   busy         high in WARMUP, RUN, DRAIN
//   tap_idx      current tap index
//   ch_idx       channel of current frame
//   frame_start  first tap strobe (doubles as DSP accumulator clear)
//   frame_last   last tap strobe
//   out_valid    result valid at DSP output, out_ch its channel
module fir_timing_ctrl
  import fir_timing_ctrl_pkg::*;
#(
  parameter  int MAX_LEN     = 16,
  parameter  int DSP_LATENCY = 4,
  parameter  int START_DELAY = 7,
  parameter  int NUM_CH      = 1,
  localparam int LEN_W       = $clog2(MAX_LEN + 1),
  localparam int TAP_W       = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1,
  localparam int CH_W        = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic [LEN_W-1:0] len_cfg,
  output logic             busy,
  output logic [TAP_W-1:0] tap_idx,
  output logic [CH_W-1:0]  ch_idx,
  output logic             frame_start,
  output logic             frame_last,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch
);

  // One down-counter serves both the warm-up and the drain period.
  localparam int CNT_MAX = (START_DELAY > DSP_LATENCY) ? START_DELAY : DSP_LATENCY;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  state_t           state;
  logic [TAP_W-1:0] tap_reg;
  logic [CH_W-1:0]  ch_reg;
  logic [LEN_W-1:0] len_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             stop_pend_reg;

  logic             run_adv;
  logic             tap_last;
  logic [LEN_W-1:0] len_next;
  logic [CH_W-1:0]  ch_wrap;

  assign run_adv  = (state == ST_RUN) && en;
  assign tap_last = (LEN_W'(tap_reg) == len_reg - LEN_W'(1));
  assign len_next = LEN_W'(clamp_len(int'(len_cfg), MAX_LEN));
  assign ch_wrap  = (ch_reg == CH_W'(NUM_CH - 1)) ? '0 : ch_reg + CH_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      tap_reg       <= '0;
      ch_reg        <= '0;
      len_reg       <= LEN_W'(MAX_LEN);
      cnt_reg       <= '0;
      stop_pend_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            len_reg       <= len_next;
            tap_reg       <= '0;
            ch_reg        <= '0;
            stop_pend_reg <= 1'b0;
            if (START_DELAY > 0) begin
              // Counter holds remaining warm-up cycles minus one so WARMUP
              // lasts exactly START_DELAY cycles.
              state   <= ST_WARMUP;
              cnt_reg <= CNT_W'(START_DELAY - 1);
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_WARMUP: begin
          if (stop) state <= ST_IDLE;
          else if (cnt_reg == '0) state <= ST_RUN;
          else cnt_reg <= cnt_reg - CNT_W'(1);
        end
        ST_RUN: begin
          if (stop) stop_pend_reg <= 1'b1;
          if (en) begin
            if (tap_last) begin
              tap_reg <= '0;
              ch_reg  <= ch_wrap;
              len_reg <= len_next;
              // A stop arriving on the last tap itself also ends the run.
              if (stop || stop_pend_reg) begin
                state   <= ST_DRAIN;
                cnt_reg <= CNT_W'(DSP_LATENCY - 1);
              end
            end else begin
              tap_reg <= tap_reg + TAP_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (cnt_reg == '0) begin
            state         <= ST_IDLE;
            tap_reg       <= '0;
            ch_reg        <= '0;
            stop_pend_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state != ST_IDLE);
  assign tap_idx     = tap_reg;
  assign ch_idx      = ch_reg;
  assign frame_start = run_adv && (tap_reg == '0);
  assign frame_last  = run_adv && tap_last;

  fir_timing_ctrl_strobe_pipe #(
    .DEPTH (DSP_LATENCY),
    .CH_W  (CH_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (frame_last),
    .in_ch     (ch_reg),
    .out_valid (out_valid),
    .out_ch    (out_ch)
  );

endmodule

// File: tb/tb_fir_timing_ctrl.sv
// Testbench: tb_fir_timing_ctrl
// Purpose: Directed checks of fir_timing_ctrl. A table of frame-length /
//   en-pattern records gives the expected strobe timing; hand-written
//   sequences cover multi-channel order, mid-frame length change, stop,
//   stop in warm-up, start&stop together and reset mid-run.
//   Two instances share stimulus: dut (NUM_CH=1) and dut3 (NUM_CH=3).
//   Cycle c: inputs driven 1 time unit after posedge c, outputs sampled at
//   the following negedge; start is driven in cycle 0.
module tb_fir_timing_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       en;
  logic [4:0] len_cfg;

  logic       busy, frame_start, frame_last, out_valid;
  logic [3:0] tap_idx;
  logic [0:0] ch_idx, out_ch;

  logic       busy3, frame_start3, frame_last3, out_valid3;
  logic [3:0] tap_idx3;
  logic [1:0] ch_idx3, out_ch3;

  int n_checks = 0;
  int n_fail   = 0;

  fir_timing_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .en          (en),
    .len_cfg     (len_cfg),
    .busy        (busy),
    .tap_idx     (tap_idx),
    .ch_idx      (ch_idx),
    .frame_start (frame_start),
    .frame_last  (frame_last),
    .out_valid   (out_valid),
    .out_ch      (out_ch)
  );

  fir_timing_ctrl #(.NUM_CH(3)) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .en          (en),
    .len_cfg     (len_cfg),
    .busy        (busy3),
    .tap_idx     (tap_idx3),
    .ch_idx      (ch_idx3),
    .frame_start (frame_start3),
    .frame_last  (frame_last3),
    .out_valid   (out_valid3),
    .out_ch      (out_ch3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] len_cfg;
    bit         en_gap;      // 1: en high on even cycles only
    int         fs_cycle;    // cycle of first frame_start
    int         fl_gap;      // first frame_last - first frame_start
    int         ov_gap;      // first out_valid - first frame_last
    int         period;      // spacing of first two out_valid pulses
    int         last_tap;    // tap_idx during first frame_last
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    en      = 1'b0;
    len_cfg = 5'd16;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Advance to cycle c: drive inputs just after posedge, then wait to negedge.
  task automatic drive_cycle(input logic s, input logic p, input logic e, input logic [4:0] l);
    @(posedge clk);
    #1;
    start   = s;
    stop    = p;
    en      = e;
    len_cfg = l;
    @(negedge clk);
  endtask

  task automatic run_row(input int idx, input vec_t v);
    int fs, fl, ov1, ov2, fl_tap;
    string tag;
    fs = -1; fl = -1; ov1 = -1; ov2 = -1; fl_tap = -1;
    tag = $sformatf("row%0d", idx);
    do_reset();
    for (int c = 0; c < 120; c++) begin
      drive_cycle(c == 0, 1'b0, v.en_gap ? (c % 2 == 0) : 1'b1, v.len_cfg);
      if (frame_start && fs < 0) fs = c;
      if (frame_last && fl < 0) begin
        fl     = c;
        fl_tap = int'(tap_idx);
      end
      if (out_valid) begin
        if (ov1 < 0) ov1 = c;
        else if (ov2 < 0) ov2 = c;
      end
    end
    check({tag, " first frame_start cycle"}, fs, v.fs_cycle);
    check({tag, " frame_start->frame_last"}, fl - fs, v.fl_gap);
    check({tag, " frame_last->out_valid"}, ov1 - fl, v.ov_gap);
    check({tag, " out_valid period"}, ov2 - ov1, v.period);
    check({tag, " tap_idx at frame_last"}, fl_tap, v.last_tap);
  endtask

  vec_t vecs[7];

  initial begin
    // Warm-up occupies cycles 1..7, so the first RUN cycle is cycle 8.
    vecs[0] = '{5'd16, 1'b0, 8, 15, 4, 16, 15};
    vecs[1] = '{5'd4,  1'b1, 8,  6, 4,  8,  3};
    vecs[2] = '{5'd0,  1'b0, 8,  1, 4,  2,  1};
    vecs[3] = '{5'd31, 1'b0, 8, 15, 4, 16, 15};
    vecs[4] = '{5'd1,  1'b0, 8,  1, 4,  2,  1};
    vecs[5] = '{5'd5,  1'b0, 8,  4, 4,  5,  4};
    vecs[6] = '{5'd2,  1'b1, 8,  2, 4,  4,  1};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset tap_idx", int'(tap_idx), 0);
    check("reset strobes", int'(frame_start) + int'(frame_last) + int'(out_valid), 0);
    check("reset out_ch3", int'(out_ch3), 0);

    for (int i = 0; i < 7; i++) run_row(i, vecs[i]);

    // Multi-channel order on dut3, len 4: frame_last at 11,15,19,23.
    begin
      int nov, bad_ch;
      int ov_c[4];
      int ov_ch[4];
      nov = 0; bad_ch = 0;
      for (int k = 0; k < 4; k++) begin ov_c[k] = -1; ov_ch[k] = -1; end
      do_reset();
      for (int c = 0; c < 40; c++) begin
        drive_cycle(c == 0, 1'b0, 1'b1, 5'd4);
        if (out_valid3) begin
          if (nov < 4) begin ov_c[nov] = c; ov_ch[nov] = int'(out_ch3); end
          nov++;
        end else if (out_ch3 != 2'd0) begin
          bad_ch++;
        end
      end
      for (int k = 0; k < 4; k++) begin
        check($sformatf("mc out_valid%0d cycle", k), ov_c[k], 15 + 4 * k);
        check($sformatf("mc out_ch%0d", k), ov_ch[k], (k == 3) ? 0 : k);
      end
      check("mc out_ch zero when idle", bad_ch, 0);
    end

    // Length change 8 -> 4 in the middle of the first frame.
    begin
      int fl1, fl2;
      fl1 = -1; fl2 = -1;
      do_reset();
      for (int c = 0; c < 30; c++) begin
        drive_cycle(c == 0, 1'b0, 1'b1, (c >= 10) ? 5'd4 : 5'd8);
        if (frame_last) begin
          if (fl1 < 0) fl1 = c;
          else if (fl2 < 0) fl2 = c;
        end
      end
      check("lenchg first frame_last", fl1, 15);
      check("lenchg second frame_last", fl2, 19);
    end

    // Stop at tap 3 of len 8 (cycle 11): frame ends 15, drain 16..19.
    begin
      int fl, ov, last_busy, fs_after, nov;
      fl = -1; ov = -1; last_busy = -1; fs_after = 0; nov = 0;
      do_reset();
      for (int c = 0; c < 60; c++) begin
        drive_cycle(c == 0, c == 11, 1'b1, 5'd8);
        if (c == 11) check("stop tap_idx at stop", int'(tap_idx), 3);
        if (frame_last && fl < 0) fl = c;
        if (out_valid) begin nov++; if (ov < 0) ov = c; end
        if (busy) last_busy = c;
        if (frame_start && c > 11) fs_after++;
      end
      check("stop frame_last cycle", fl, 15);
      check("stop out_valid cycle", ov, 19);
      check("stop last busy cycle", last_busy, 19);
      check("stop no new frame", fs_after, 0);
      check("stop out_valid count", nov, 1);
    end

    // Stop during warm-up (cycle 3).
    begin
      int strobes;
      strobes = 0;
      do_reset();
      for (int c = 0; c < 40; c++) begin
        drive_cycle(c == 0, c == 3, 1'b1, 5'd4);
        if (c == 3) check("warmstop busy at stop", int'(busy), 1);
        if (c == 4) check("warmstop busy after", int'(busy), 0);
        strobes += int'(frame_start) + int'(frame_last) + int'(out_valid);
      end
      check("warmstop strobes", strobes, 0);
    end

    // start and stop together in IDLE.
    begin
      int nbusy;
      nbusy = 0;
      do_reset();
      for (int c = 0; c < 12; c++) begin
        drive_cycle(c == 0, c == 0, 1'b1, 5'd4);
        nbusy += int'(busy);
      end
      check("start&stop busy cycles", nbusy, 0);
    end

    // Reset mid-RUN just after a frame_last (len 4, frame_last at 11).
    begin
      int nov;
      nov = 0;
      do_reset();
      for (int c = 0; c <= 12; c++) drive_cycle(c == 0, 1'b0, 1'b1, 5'd4);
      check("midrst busy before", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst busy", int'(busy), 0);
      check("midrst tap_idx", int'(tap_idx), 0);
      check("midrst ch_idx3", int'(ch_idx3), 0);
      check("midrst strobes", int'(frame_start) + int'(frame_last) + int'(out_valid), 0);
      check("midrst out_ch3", int'(out_ch3), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
        drive_cycle(1'b0, 1'b0, 1'b1, 5'd4);
        nov += int'(out_valid) + int'(out_valid3) + int'(busy);
      end
      check("midrst quiet after release", nov, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
